// File: rtl/rdmem_port_arbiter.sv
// Round-robin arbiter sharing the ReadMem data-memory port between the pipeline (rq0) and
// debug/DMA (rq1); registers the memory request and routes in-order responses back by ID.
module rdmem_port_arbiter #(
   parameter int unsigned ADDR_WIDTH  = 32,
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned OUTSTANDING = 2
) (
   input  logic                    clk,
   input  logic                    rst,

   input  logic                    rq0_valid,
   output logic                    rq0_ready,
   input  logic                    rq0_we,
   input  logic [ADDR_WIDTH-3:0]   rq0_addr,
   input  logic [DATA_WIDTH-1:0]   rq0_wdata,
   input  logic [DATA_WIDTH/8-1:0] rq0_be,

   input  logic                    rq1_valid,
   output logic                    rq1_ready,
   input  logic                    rq1_we,
   input  logic [ADDR_WIDTH-3:0]   rq1_addr,
   input  logic [DATA_WIDTH-1:0]   rq1_wdata,
   input  logic [DATA_WIDTH/8-1:0] rq1_be,

   output logic                    rs0_valid,
   output logic [DATA_WIDTH-1:0]   rs0_rdata,
   output logic                    rs1_valid,
   output logic [DATA_WIDTH-1:0]   rs1_rdata,

   output logic                    mem_valid,
   input  logic                    mem_ready,
   output logic                    mem_we,
   output logic [ADDR_WIDTH-3:0]   mem_addr,
   output logic [DATA_WIDTH-1:0]   mem_wdata,
   output logic [DATA_WIDTH/8-1:0] mem_be,
   input  logic                    mem_rsp_valid,
   input  logic [DATA_WIDTH-1:0]   mem_rsp_rdata,

   output logic                    err
);

   localparam int unsigned AW = ADDR_WIDTH - 2;
   localparam int unsigned BW = DATA_WIDTH / 8;
   localparam int unsigned CW = $clog2(OUTSTANDING + 1);
   localparam int unsigned PW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;

   localparam logic [CW-1:0] MaxCnt  = CW'(OUTSTANDING);
   localparam logic [PW-1:0] LastPtr = PW'(OUTSTANDING - 1);

   logic            mem_valid_q;
   logic            mem_we_q;
   logic [AW-1:0]   mem_addr_q;
   logic [DATA_WIDTH-1:0] mem_wdata_q;
   logic [BW-1:0]   mem_be_q;

   logic            rr_last_q;
   logic [CW-1:0]   out_cnt_q, out_cnt_d;
   logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
   logic            id_fifo_q [OUTSTANDING];

   logic            rs0_valid_q, rs1_valid_q;
   logic [DATA_WIDTH-1:0] rs0_rdata_q, rs1_rdata_q;
   logic            err_q;

   logic slot_free, can_accept, grant, accept, rsp_take, rsp_id;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == LastPtr) ? '0 : p + PW'(1);
   endfunction

   always_comb begin
      slot_free  = !mem_valid_q || mem_ready;
      // Readies are held low while reset is asserted.
      can_accept = rst && slot_free && (out_cnt_q < MaxCnt);
      grant      = (rq0_valid && rq1_valid) ? !rr_last_q : rq1_valid;
      accept     = can_accept && (rq0_valid || rq1_valid);
      rq0_ready  = can_accept && rq0_valid && !grant;
      rq1_ready  = can_accept && rq1_valid && grant;
      rsp_take   = mem_rsp_valid && (out_cnt_q != '0);
      rsp_id     = id_fifo_q[rd_ptr_q];
   end

   always_comb begin
      out_cnt_d = out_cnt_q;
      if (accept && !rsp_take) begin
         out_cnt_d = out_cnt_q + CW'(1);
      end else if (!accept && rsp_take) begin
         out_cnt_d = out_cnt_q - CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem_valid_q <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_be_q    <= '0;
         rr_last_q   <= 1'b1;
         out_cnt_q   <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         rs0_valid_q <= 1'b0;
         rs1_valid_q <= 1'b0;
         rs0_rdata_q <= '0;
         rs1_rdata_q <= '0;
         err_q       <= 1'b0;
         for (int i = 0; i < OUTSTANDING; i++) begin
            id_fifo_q[i] <= 1'b0;
         end
      end else begin
         if (accept) begin
            mem_valid_q           <= 1'b1;
            mem_we_q              <= grant ? rq1_we    : rq0_we;
            mem_addr_q            <= grant ? rq1_addr  : rq0_addr;
            mem_wdata_q           <= grant ? rq1_wdata : rq0_wdata;
            mem_be_q              <= grant ? rq1_be    : rq0_be;
            rr_last_q             <= grant;
            id_fifo_q[wr_ptr_q]   <= grant;
            wr_ptr_q              <= ptr_inc(wr_ptr_q);
         end else if (mem_ready) begin
            mem_valid_q <= 1'b0;
         end

         if (rsp_take) begin
            rd_ptr_q <= ptr_inc(rd_ptr_q);
         end
         out_cnt_q <= out_cnt_d;

         rs0_valid_q <= rsp_take && !rsp_id;
         rs1_valid_q <= rsp_take && rsp_id;
         if (rsp_take && !rsp_id) begin
            rs0_rdata_q <= mem_rsp_rdata;
         end
         if (rsp_take && rsp_id) begin
            rs1_rdata_q <= mem_rsp_rdata;
         end

         // A response with nothing in flight is dropped and flagged until reset.
         if (mem_rsp_valid && (out_cnt_q == '0)) begin
            err_q <= 1'b1;
         end
      end
   end

   assign mem_valid = mem_valid_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_be    = mem_be_q;
   assign rs0_valid = rs0_valid_q;
   assign rs0_rdata = rs0_rdata_q;
   assign rs1_valid = rs1_valid_q;
   assign rs1_rdata = rs1_rdata_q;
   assign err       = err_q;

endmodule

// File: tb/tb_rdmem_port_arbiter.sv
// Scoreboard bench for rdmem_port_arbiter: directed stimulus pushes expected memory requests and
// responses into queues; a negedge monitor pops and compares whenever the DUT presents them.
module tb_rdmem_port_arbiter;

   typedef struct packed {
      logic        we;
      logic [29:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
   } req_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        rq0_valid = 1'b0, rq0_ready, rq0_we = 1'b0;
   logic [29:0] rq0_addr = '0;
   logic [31:0] rq0_wdata = '0;
   logic [3:0]  rq0_be = '0;
   logic        rq1_valid = 1'b0, rq1_ready, rq1_we = 1'b0;
   logic [29:0] rq1_addr = '0;
   logic [31:0] rq1_wdata = '0;
   logic [3:0]  rq1_be = '0;
   logic        rs0_valid, rs1_valid;
   logic [31:0] rs0_rdata, rs1_rdata;
   logic        mem_valid, mem_ready = 1'b1, mem_we;
   logic [29:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_rsp_valid;
   logic [31:0] mem_rsp_rdata;
   logic        err;

   rdmem_port_arbiter dut (
      .clk(clk), .rst(rst),
      .rq0_valid(rq0_valid), .rq0_ready(rq0_ready), .rq0_we(rq0_we), .rq0_addr(rq0_addr),
      .rq0_wdata(rq0_wdata), .rq0_be(rq0_be),
      .rq1_valid(rq1_valid), .rq1_ready(rq1_ready), .rq1_we(rq1_we), .rq1_addr(rq1_addr),
      .rq1_wdata(rq1_wdata), .rq1_be(rq1_be),
      .rs0_valid(rs0_valid), .rs0_rdata(rs0_rdata), .rs1_valid(rs1_valid), .rs1_rdata(rs1_rdata),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rsp_valid(mem_rsp_valid),
      .mem_rsp_rdata(mem_rsp_rdata), .err(err)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_pass = 0;
   req_t        exp_mem[$];
   req_t        q0[$];
   req_t        q1[$];
   logic [31:0] exp_rs0[$];
   logic [31:0] exp_rs1[$];
   logic [31:0] rsp_data_q[$];
   int          glog[$];
   logic        mem_hold = 1'b0;
   logic        spur = 1'b0;
   int          mem_acc;
   logic        mem_hs;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      $display("FAIL %s: bound expired, got no completion, required completion", name);
   endtask

   function automatic req_t mk(input logic we, input logic [29:0] a, input logic [31:0] d,
                               input logic [3:0] be);
      return req_t'({we, a, d, be});
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_rq(input int n, input logic v, input req_t r);
      if (n == 0) begin
         rq0_valid = v;
         {rq0_we, rq0_addr, rq0_wdata, rq0_be} = r;
      end else begin
         rq1_valid = v;
         {rq1_we, rq1_addr, rq1_wdata, rq1_be} = r;
      end
   endtask

   // Presents the heads of q0/q1 until both are consumed; logs grant order.
   task automatic run_streams(input int max_cyc);
      int  n = 0;
      logic h0, h1;
      while ((q0.size() > 0 || q1.size() > 0) && n < max_cyc) begin
         set_rq(0, q0.size() > 0, (q0.size() > 0) ? q0[0] : '0);
         set_rq(1, q1.size() > 0, (q1.size() > 0) ? q1[0] : '0);
         @(negedge clk);
         h0 = rq0_valid && rq0_ready;
         h1 = rq1_valid && rq1_ready;
         if (h0) glog.push_back(0);
         if (h1) glog.push_back(1);
         step();
         if (h0) void'(q0.pop_front());
         if (h1) void'(q1.pop_front());
         n++;
      end
      rq0_valid = 1'b0;
      rq1_valid = 1'b0;
      if (n >= max_cyc) fail_now("stream_timeout");
   endtask

   task automatic drain(input int max_cyc);
      int n = 0;
      while ((exp_mem.size() > 0 || exp_rs0.size() > 0 || exp_rs1.size() > 0) && n < max_cyc) begin
         step();
         n++;
      end
      if (n >= max_cyc) fail_now("drain_timeout");
      repeat (3) step();
   endtask

   // Memory model: answers each handshake one cycle later with the next queued data word.
   initial begin
      mem_rsp_valid = 1'b0;
      mem_rsp_rdata = '0;
      mem_acc = 0;
      forever begin
         @(negedge clk);
         mem_hs = mem_valid && mem_ready && rst;
         @(posedge clk);
         #2;
         if (!rst) begin
            mem_acc = 0;
            mem_rsp_valid = 1'b0;
         end else begin
            if (mem_hs) mem_acc++;
            if (spur) begin
               mem_rsp_valid = 1'b1;
               mem_rsp_rdata = 32'h5A5A_5A5A;
               spur = 1'b0;
            end else if (!mem_hold && mem_acc > 0 && rsp_data_q.size() > 0) begin
               mem_rsp_valid = 1'b1;
               mem_rsp_rdata = rsp_data_q.pop_front();
               mem_acc--;
            end else begin
               mem_rsp_valid = 1'b0;
            end
         end
      end
   end

   // Monitor: compares every memory handshake and response pulse against the scoreboard.
   always @(negedge clk) begin
      if (rst) begin
         if (mem_valid && mem_ready) begin
            if (exp_mem.size() == 0) begin
               n_checks++;
               $display("FAIL mem_unexpected: got request addr 0x%0h, required none", mem_addr);
            end else begin
               check("mem_req", {mem_we, mem_addr, mem_wdata, mem_be}, exp_mem.pop_front());
            end
         end
         if (rs0_valid) begin
            if (exp_rs0.size() == 0) begin
               n_checks++;
               $display("FAIL rs0_unexpected: got pulse data 0x%0h, required none", rs0_rdata);
            end else begin
               check("rs0_rdata", rs0_rdata, exp_rs0.pop_front());
            end
         end
         if (rs1_valid) begin
            if (exp_rs1.size() == 0) begin
               n_checks++;
               $display("FAIL rs1_unexpected: got pulse data 0x%0h, required none", rs1_rdata);
            end else begin
               check("rs1_rdata", rs1_rdata, exp_rs1.pop_front());
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish, required finish before 100000");
      $fatal(1, "watchdog");
   end

   initial begin
      int exp_g[4];

      // Reset values, readies gated while in reset.
      rq0_valid = 1'b1;
      rq1_valid = 1'b1;
      @(negedge clk);
      check("reset_ctrl", {mem_valid, rs0_valid, rs1_valid, err, rq0_ready, rq1_ready}, 6'b0);
      check("reset_data", {mem_we, mem_addr, mem_wdata, mem_be, rs0_rdata, rs1_rdata}, '0);
      step();
      rq0_valid = 1'b0;
      rq1_valid = 1'b0;
      rst = 1'b1;
      step();

      // Tie fairness: grant order 0,1,0,1 with immediate responses.
      glog.delete();
      q0.push_back(mk(1'b0, 30'h20, 32'h0, 4'hF));
      q0.push_back(mk(1'b0, 30'h21, 32'h0, 4'hF));
      q1.push_back(mk(1'b1, 30'h30, 32'h1111, 4'h3));
      q1.push_back(mk(1'b1, 30'h31, 32'h2222, 4'hC));
      exp_mem.push_back(mk(1'b0, 30'h20, 32'h0, 4'hF));
      exp_mem.push_back(mk(1'b1, 30'h30, 32'h1111, 4'h3));
      exp_mem.push_back(mk(1'b0, 30'h21, 32'h0, 4'hF));
      exp_mem.push_back(mk(1'b1, 30'h31, 32'h2222, 4'hC));
      rsp_data_q.push_back(32'hA0); rsp_data_q.push_back(32'hB1);
      rsp_data_q.push_back(32'hA2); rsp_data_q.push_back(32'hB3);
      exp_rs0.push_back(32'hA0); exp_rs0.push_back(32'hA2);
      exp_rs1.push_back(32'hB1); exp_rs1.push_back(32'hB3);
      run_streams(60);
      exp_g = '{0, 1, 0, 1};
      check("fair_len", glog.size(), 4);
      for (int i = 0; i < glog.size() && i < 4; i++) check("fair_grant", glog[i], exp_g[i]);
      drain(60);

      // Single read with latency checks.
      exp_mem.push_back(mk(1'b0, 30'h10, 32'h0, 4'hF));
      rsp_data_q.push_back(32'hDEADBEEF);
      exp_rs0.push_back(32'hDEADBEEF);
      set_rq(0, 1'b1, mk(1'b0, 30'h10, 32'h0, 4'hF));
      @(negedge clk);
      check("single_ready", {rq0_ready, mem_valid}, 2'b10);
      step();
      rq0_valid = 1'b0;
      @(negedge clk);
      check("single_lat", {mem_valid, mem_we, mem_addr}, {1'b1, 1'b0, 30'h10});
      step();
      @(negedge clk);
      check("single_rsp_pre", {rs0_valid, rs1_valid, mem_valid}, 3'b000);
      step();
      @(negedge clk);
      check("single_rsp", {rs0_valid, rs1_valid, rs0_rdata}, {2'b10, 32'hDEADBEEF});
      step();
      @(negedge clk);
      check("single_pulse_end", {rs0_valid, rs1_valid}, 2'b00);
      drain(20);

      // Credit limit: three reads from rq1, responses withheld.
      mem_hold = 1'b1;
      for (int i = 0; i < 3; i++) begin
         exp_mem.push_back(mk(1'b0, 30'h40 + 30'(i), 32'h0, 4'hF));
         rsp_data_q.push_back(32'hC0 + 32'(i));
         exp_rs1.push_back(32'hC0 + 32'(i));
      end
      set_rq(1, 1'b1, mk(1'b0, 30'h40, 32'h0, 4'hF));
      @(negedge clk);
      check("credit_acc0", rq1_ready, 1'b1);
      step();
      set_rq(1, 1'b1, mk(1'b0, 30'h41, 32'h0, 4'hF));
      @(negedge clk);
      check("credit_acc1", rq1_ready, 1'b1);
      step();
      set_rq(1, 1'b1, mk(1'b0, 30'h42, 32'h0, 4'hF));
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("credit_full", {rq0_ready, rq1_ready}, 2'b00);
         step();
      end
      mem_hold = 1'b0;
      @(negedge clk);
      check("credit_release_same", rq1_ready, 1'b0);
      step();
      @(negedge clk);
      check("credit_reopen", rq1_ready, 1'b1);
      step();
      rq1_valid = 1'b0;
      drain(30);

      // Backpressure: slot held while mem_ready is low.
      mem_ready = 1'b0;
      exp_mem.push_back(mk(1'b1, 30'h50, 32'hCAFEF00D, 4'h5));
      exp_mem.push_back(mk(1'b0, 30'h60, 32'h0, 4'hF));
      rsp_data_q.push_back(32'hD0); rsp_data_q.push_back(32'hD1);
      exp_rs0.push_back(32'hD0);
      exp_rs1.push_back(32'hD1);
      set_rq(0, 1'b1, mk(1'b1, 30'h50, 32'hCAFEF00D, 4'h5));
      @(negedge clk);
      check("bp_accept", rq0_ready, 1'b1);
      step();
      rq0_valid = 1'b0;
      set_rq(1, 1'b1, mk(1'b0, 30'h60, 32'h0, 4'hF));
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_ready", {rq0_ready, rq1_ready}, 2'b00);
         check("bp_stable", {mem_valid, mem_we, mem_addr, mem_wdata, mem_be},
               {1'b1, 1'b1, 30'h50, 32'hCAFEF00D, 4'h5});
         step();
      end
      mem_ready = 1'b1;
      @(negedge clk);
      check("bp_next", rq1_ready, 1'b1);
      step();
      rq1_valid = 1'b0;
      drain(30);

      // Simultaneous accept and response at one outstanding.
      exp_mem.push_back(mk(1'b0, 30'h70, 32'h0, 4'hF));
      exp_mem.push_back(mk(1'b0, 30'h71, 32'h0, 4'hF));
      exp_mem.push_back(mk(1'b0, 30'h72, 32'h0, 4'hF));
      rsp_data_q.push_back(32'hE0); rsp_data_q.push_back(32'hE1); rsp_data_q.push_back(32'hE2);
      exp_rs0.push_back(32'hE0);
      exp_rs1.push_back(32'hE1);
      exp_rs0.push_back(32'hE2);
      set_rq(0, 1'b1, mk(1'b0, 30'h70, 32'h0, 4'hF));
      @(negedge clk);
      check("simul_first", rq0_ready, 1'b1);
      step();
      rq0_valid = 1'b0;
      step();
      set_rq(1, 1'b1, mk(1'b0, 30'h71, 32'h0, 4'hF));
      @(negedge clk);
      check("simul_ready", rq1_ready, 1'b1);
      step();
      mem_hold = 1'b1;
      rq1_valid = 1'b0;
      set_rq(0, 1'b1, mk(1'b0, 30'h72, 32'h0, 4'hF));
      @(negedge clk);
      check("simul_cnt1", rq0_ready, 1'b1);
      step();
      rq0_valid = 1'b0;
      set_rq(1, 1'b1, mk(1'b0, 30'h73, 32'h0, 4'hF));
      @(negedge clk);
      check("simul_full", {rq0_ready, rq1_ready}, 2'b00);
      step();
      rq1_valid = 1'b0;
      mem_hold = 1'b0;
      drain(30);

      // Spurious response after reset, then reset in the middle of a burst.
      rst = 1'b0;
      step();
      rst = 1'b1;
      step();
      spur = 1'b1;
      @(negedge clk);
      check("spur_pre", err, 1'b0);
      step();
      @(negedge clk);
      check("spur_err", {err, rs0_valid, rs1_valid}, 3'b100);
      repeat (3) step();
      @(negedge clk);
      check("err_sticky", err, 1'b1);
      step();
      mem_hold = 1'b1;
      exp_mem.push_back(mk(1'b0, 30'h90, 32'h0, 4'hF));
      set_rq(1, 1'b1, mk(1'b0, 30'h90, 32'h0, 4'hF));
      @(negedge clk);
      check("burst_rq1", rq1_ready, 1'b1);
      step();
      rq1_valid = 1'b0;
      set_rq(0, 1'b1, mk(1'b0, 30'h80, 32'h0, 4'hF));
      @(negedge clk);
      check("burst_rq0", rq0_ready, 1'b1);
      step();
      rq0_valid = 1'b0;
      rst = 1'b0;
      #1;
      check("reset_async", {mem_valid, mem_we, mem_addr, mem_wdata, mem_be, rs0_valid, rs1_valid,
                            err, rq0_ready, rq1_ready}, '0);
      check("reset_rdata", {rs0_rdata, rs1_rdata}, '0);
      mem_hold = 1'b0;
      step();
      rst = 1'b1;
      step();

      // After reset, a tie goes to requester 0 again.
      glog.delete();
      q0.push_back(mk(1'b0, 30'hA0, 32'h0, 4'hF));
      q1.push_back(mk(1'b0, 30'hA1, 32'h0, 4'hF));
      exp_mem.push_back(mk(1'b0, 30'hA0, 32'h0, 4'hF));
      exp_mem.push_back(mk(1'b0, 30'hA1, 32'h0, 4'hF));
      rsp_data_q.push_back(32'hF0); rsp_data_q.push_back(32'hF1);
      exp_rs0.push_back(32'hF0);
      exp_rs1.push_back(32'hF1);
      run_streams(30);
      check("post_reset_len", glog.size(), 2);
      for (int i = 0; i < glog.size() && i < 2; i++) check("post_reset_tie", glog[i], exp_g[i]);
      drain(30);
      check("queues_empty", exp_mem.size() + exp_rs0.size() + exp_rs1.size(), 0);
      check("err_clear", err, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/rdmem_port_arbiter.md
# rdmem_port_arbiter

Shares the single data-memory port used by the ReadMem pipeline stage between two requesters: requester 0 (ReadMem stage load/store traffic) and requester 1 (debug/DMA access). It arbitrates round-robin with valid/ready handshakes and registers the outgoing memory request. It tracks up to OUTSTANDING in-flight accesses and routes in-order memory responses back to the requester that issued them.

## Interface
- ADDR_WIDTH, 32: byte-address width; address ports carry word address bits [ADDR_WIDTH-1:2] (width ADDR_WIDTH-2).
- DATA_WIDTH, 32: data width; byte-enable width is DATA_WIDTH/8.
- OUTSTANDING, 2: max accepted-but-unanswered requests; ≥1. Counter width is $clog2(OUTSTANDING+1).

- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- rqN_valid  in  1  requester N (N=0,1) has a request.
- rqN_ready  out  1  request N accepted this cycle when valid&ready.
- rqN_we  in  1  1=write, 0=read.
- rqN_addr  in  ADDR_WIDTH-2  word address.
- rqN_wdata  in  DATA_WIDTH  write data.
- rqN_be  in  DATA_WIDTH/8  byte enables.
- rsN_valid  out  1  one-cycle response pulse to requester N.
- rsN_rdata  out  DATA_WIDTH  read data (don't-care for writes).
- mem_valid  out  1  registered request to memory.
- mem_ready  in  1  memory accepts request when mem_valid&mem_ready.
- mem_we, mem_addr, mem_wdata, mem_be  out  as rqN_*  registered request fields.
- mem_rsp_valid  in  1  memory returns one response, in request order, for every accepted read or write.
- mem_rsp_rdata  in  DATA_WIDTH  response data.
- err  out  1  sticky protocol error.

## Operation
- Output slot: one register holding {we, addr, wdata, be, id}. slot_free = !mem_valid | mem_ready.
- Credit: out_cnt counts requests accepted into the slot and not yet answered. can_accept = slot_free & (out_cnt < OUTSTANDING).
- Arbitration, combinational from current state: if can_accept and exactly one rqN_valid, grant N. If both are valid, grant the requester other than rr_last. rqN_ready = can_accept & grant==N. At most one rqN_ready is high per cycle.
- On accept: load slot with the granted requester's fields, set mem_valid=1, rr_last<=N, push N into the ID FIFO (depth OUTSTANDING), out_cnt++.
- On mem_valid&mem_ready with no new accept: mem_valid<=0. Slot fields hold while mem_valid&!mem_ready.
- On mem_rsp_valid with out_cnt>0: pop ID. Next cycle, pulse rs{ID}_valid=1 with rs{ID}_rdata=mem_rsp_rdata; out_cnt--.
- Accept and response in the same cycle: out_cnt is unchanged; FIFO push and pop both occur.
- mem_rsp_valid with out_cnt==0: response ignored (no pop, no rs pulse), err<=1 and stays 1 until reset.
- Requester valid may deassert without a handshake. No ordering or hold requirement is placed on requesters.

## Timing
- Reset (rst=0, async): mem_valid=0, mem_we/addr/wdata/be=0, rs0_valid=rs1_valid=0, rs0/1_rdata=0, err=0, out_cnt=0, FIFO empty, rr_last=1 (requester 0 wins the first tie). rqN_ready=0 while in reset.
- Reset mid-operation: all in-flight state is discarded. The memory shares rst, so no stale responses arrive.
- Request latency: accepted at edge N → mem_valid=1 with the fields after edge N (visible in cycle N+1).
- Back-to-back: with mem_ready held at 1 and credit available, one request is accepted every cycle.
- Response latency: mem_rsp_valid sampled at edge M → rsN_valid high for exactly cycle M+1.
- Credit full (out_cnt==OUTSTANDING): both readies are 0. A response at edge M frees credit, so the next accept is possible in cycle M+1.
- FIFO pointers wrap modulo OUTSTANDING. Full/empty is derived from out_cnt.

## Test plan
- Single read: rq0 read addr 0x10 → mem_valid the next cycle with mem_addr=0x10, we=0. Memory returns 0xDEADBEEF → rs0_valid pulses 1 cycle later with rs0_rdata=0xDEADBEEF; rs1_valid stays 0.
- Tie fairness: both requesters valid continuously, mem_ready=1, immediate responses → grant order 0,1,0,1. Responses route rs0, rs1, rs0, rs1 with matching data.
- Credit limit (OUTSTANDING=2): rq1 issues 3 reads, memory withholds responses → only 2 accepted and rq1_ready=0. The first response re-opens acceptance in the following cycle.
- Backpressure: mem_ready=0 for 5 cycles with a request in the slot → mem_* fields stable, rq0_ready=rq1_ready=0. mem_ready=1 → handshake completes, then the next request issues.
- Simultaneous accept and response at out_cnt=1 → out_cnt stays 1, IDs remain in order.
- Spurious mem_rsp_valid after reset with nothing outstanding → err=1 sticky, no rs pulse. Asserting rst=0 mid-burst → all outputs 0 immediately, err cleared.
